// File: rtl/fifo_reader_pkg.sv
// Shared constants and types for the FIFO read-side master.
package fifo_reader_pkg;

   localparam int unsigned FIFO_WIDTH_DEFAULT = 16;
   localparam int unsigned STATS_W            = 16;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StHold
   } state_e;

endpackage

// File: rtl/reader_skid_buf.sv
// Circular output buffer for fifo_reader: push/pop, occupancy, registered head word.
module reader_skid_buf #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         ready,
   output logic [WIDTH-1:0]             head_data,
   output logic                         head_valid,
   output logic [$clog2(DEPTH+1)-1:0]   occ
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_next;
   logic [OCC_W-1:0] occ_q;
   logic [WIDTH-1:0] head_q, head_d;
   logic             pop, do_push;

   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign head_valid = (occ_q != '0);
   assign pop        = head_valid && ready;
   assign do_push    = push && ((occ_q != OCC_W'(DEPTH)) || pop);
   assign rd_next    = wrap_inc(rd_ptr_q);

   // Head is registered so m_data keeps its last value once the buffer drains.
   always_comb begin
      head_d = head_q;
      if (pop) begin
         if (occ_q > OCC_W'(1)) begin
            head_d = mem[rd_next];
         end else if (do_push) begin
            head_d = push_data;
         end
      end else if ((occ_q == '0) && do_push) begin
         head_d = push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         head_q   <= '0;
      end else begin
         head_q <= head_d;
         if (do_push) wr_ptr_q <= wrap_inc(wr_ptr_q);
         if (pop)     rd_ptr_q <= rd_next;
         if (do_push && !pop)      occ_q <= occ_q + 1'b1;
         else if (!do_push && pop) occ_q <= occ_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= push_data;
   end

   assign head_data = head_q;
   assign occ       = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// FIFO read-side master with credit-based issue into a small output buffer.
// Define FIFO_READER_STATS_EN to add saturating rd_count / stall_count outputs.
module fifo_reader
   import fifo_reader_pkg::*;
#(
   parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEFAULT,
   parameter int unsigned BUF_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  fifo_empty,
   input  logic                  fifo_underflow,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   output logic                  fifo_rd_en,
   output logic [FIFO_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  busy,
   output logic                  underflow_err
`ifdef FIFO_READER_STATS_EN
   ,
   output logic [STATS_W-1:0]    rd_count,
   output logic [STATS_W-1:0]    stall_count
`endif
);

   localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);
   localparam logic [OCC_W:0] DEPTH_C = (OCC_W + 1)'(BUF_DEPTH);

   state_e           state_q, state_d;
   logic             pend_q, err_q, push, credit_ok;
   logic [OCC_W-1:0] occ;
   logic [OCC_W:0]   credit;

   // A read is only issued if the buffer can hold every word already in flight.
   assign credit    = {1'b0, occ} + {{OCC_W{1'b0}}, pend_q};
   assign credit_ok = (credit < DEPTH_C);
   assign push      = pend_q && !fifo_underflow;

   always_comb begin
      state_d    = state_q;
      fifo_rd_en = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (en) state_d = StRun;
         end
         StRun: begin
            fifo_rd_en = en && !fifo_empty && credit_ok;
            if (!en)             state_d = StIdle;
            else if (!credit_ok) state_d = StHold;
         end
         StHold: begin
            if (!en)            state_d = StIdle;
            else if (credit_ok) state_d = StRun;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         pend_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= fifo_rd_en;
         if (pend_q && fifo_underflow) err_q <= 1'b1;
      end
   end

   reader_skid_buf #(
      .WIDTH (FIFO_WIDTH),
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_data  (fifo_data_out),
      .ready      (m_ready),
      .head_data  (m_data),
      .head_valid (m_valid),
      .occ        (occ)
   );

   assign busy          = (state_q != StIdle) || (occ != '0) || pend_q;
   assign underflow_err = err_q;

`ifdef FIFO_READER_STATS_EN
   logic [STATS_W-1:0] rd_cnt_q, stall_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (push && (rd_cnt_q != '1)) rd_cnt_q <= rd_cnt_q + 1'b1;
         if (m_valid && !m_ready && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end

   assign rd_count    = rd_cnt_q;
   assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: directed scenarios plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_fifo_reader;

   localparam int unsigned W = 16;
   localparam int unsigned D = 4;

   logic         clk = 1'b0;
   logic         rst_n, en, fifo_empty, fifo_underflow, m_ready;
   logic [W-1:0] fifo_data_out;
   logic         fifo_rd_en, m_valid, busy, underflow_err;
   logic [W-1:0] m_data;
`ifdef FIFO_READER_STATS_EN
   logic [15:0]  rd_count, stall_count;
`endif

   always #5 clk = ~clk;

   fifo_reader #(
      .FIFO_WIDTH (W),
      .BUF_DEPTH  (D)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .en             (en),
      .fifo_empty     (fifo_empty),
      .fifo_underflow (fifo_underflow),
      .fifo_data_out  (fifo_data_out),
      .fifo_rd_en     (fifo_rd_en),
      .m_data         (m_data),
      .m_valid        (m_valid),
      .m_ready        (m_ready),
      .busy           (busy),
      .underflow_err  (underflow_err)
`ifdef FIFO_READER_STATS_EN
      ,
      .rd_count       (rd_count),
      .stall_count    (stall_count)
`endif
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // Bench-side FIFO contents and stimulus knobs
   logic [W-1:0] fifo_q[$];
   bit           noise, uf_once, watch_busy;

   // Behavioural model: buffered words, one in-flight read, run/hold bookkeeping
   logic [W-1:0] mq[$];
   logic [W-1:0] m_last;
   bit           m_pend, m_active, m_hold, m_err;
   int           m_rdc, m_stc;

   // Observations of the DUT for directed checks
   logic [W-1:0] got[$];
   int           got_cyc[$];
   int           rd_total, first_rd, first_val, busy_low;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic fifo_push(input logic [W-1:0] w);
      fifo_q.push_back(w);
      fifo_empty = 1'b0;
   endtask

   task automatic clear_logs();
      got.delete();
      got_cyc.delete();
      rd_total  = 0;
      first_rd  = -1;
      first_val = -1;
      busy_low  = -1;
   endtask

   task automatic step();
      int           sz;
      bit           exp_valid, exp_rd, exp_busy, full_now, act_rd;
      logic [W-1:0] exp_data;
      @(negedge clk);
      act_rd    = (fifo_rd_en === 1'b1);
      sz        = mq.size();
      exp_valid = (sz > 0);
      exp_data  = exp_valid ? mq[0] : m_last;
      exp_rd    = m_active && !m_hold && en && !fifo_empty && ((sz + int'(m_pend)) < D);
      exp_busy  = m_active || (sz > 0) || m_pend;
      if (rst_n) begin
         check("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
         check("m_valid", 32'(m_valid), 32'(exp_valid));
         check("m_data", 32'(m_data), 32'(exp_data));
         check("busy", 32'(busy), 32'(exp_busy));
         check("underflow_err", 32'(underflow_err), 32'(m_err));
`ifdef FIFO_READER_STATS_EN
         check("rd_count", 32'(rd_count), 32'(m_rdc));
         check("stall_count", 32'(stall_count), 32'(m_stc));
`endif
         if (act_rd) begin
            rd_total++;
            if (first_rd < 0) first_rd = cyc;
         end
         if (m_valid === 1'b1) begin
            if (first_val < 0) first_val = cyc;
            if (m_ready) begin
               got.push_back(m_data);
               got_cyc.push_back(cyc);
            end
         end
         if (watch_busy && (busy === 1'b0) && (busy_low < 0)) busy_low = cyc;
      end
      if (!rst_n) begin
         mq.delete();
         m_pend = 0; m_active = 0; m_hold = 0; m_err = 0;
         m_last = '0; m_rdc = 0; m_stc = 0;
      end else begin
         full_now = (sz + int'(m_pend)) >= D;
         if (exp_valid && !m_ready && m_stc < 65535) m_stc++;
         if (exp_valid && m_ready) void'(mq.pop_front());
         if (m_pend) begin
            if (fifo_underflow) m_err = 1;
            else begin
               mq.push_back(fifo_data_out);
               if (m_rdc < 65535) m_rdc++;
            end
         end
         if (mq.size() > 0) m_last = mq[0];
         if (!en) begin
            m_active = 0; m_hold = 0;
         end else if (!m_active) begin
            m_active = 1; m_hold = 0;
         end else begin
            m_hold = full_now;
         end
         m_pend = exp_rd;
      end
      @(posedge clk);
      #1;
      cyc++;
      // FIFO answers the read accepted at this edge
      if (act_rd) begin
         if (fifo_q.size() > 0) begin
            fifo_data_out  = fifo_q.pop_front();
            fifo_underflow = uf_once || (noise && $urandom_range(0, 39) == 0);
         end else begin
            fifo_data_out  = W'($urandom);
            fifo_underflow = 1'b1;
         end
         uf_once = 0;
      end else begin
         if (noise) fifo_data_out = W'($urandom);
         fifo_underflow = noise && ($urandom_range(0, 9) == 0);
      end
      fifo_empty = (fifo_q.size() == 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      en    = 1'b0;
      fifo_q.delete();
      fifo_empty = 1'b1;
      step();
      rst_n = 1'b1;
      clear_logs();
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1;
      fifo_underflow = 1'b0; fifo_data_out = '0;
      noise = 0; uf_once = 0; watch_busy = 0;
      m_pend = 0; m_active = 0; m_hold = 0; m_err = 0; m_last = '0; m_rdc = 0; m_stc = 0;
      clear_logs();
      step();
      step();

      // Reset mid-burst: occ=2 and a read in flight when reset hits
      rst_n = 1'b1;
      for (int i = 1; i <= 10; i++) fifo_push(W'(i));
      en = 1'b1;
      repeat (4) step();
      check("burst_m_valid", 32'(m_valid), 32'd1);
      check("burst_m_data", 32'(m_data), 32'h0001);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(underflow_err), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);

      // Streaming: 8 words, one per cycle, two-cycle latency
      do_reset();
      for (int i = 1; i <= 8; i++) fifo_push(W'(i));
      en = 1'b1; m_ready = 1'b1;
      repeat (20) step();
      check("stream_rd_count", 32'(rd_total), 32'd8);
      check("stream_latency", 32'(first_val - first_rd), 32'd2);
      check("stream_words", 32'(got.size()), 32'd8);
      for (int i = 0; i < got.size() && i < 8; i++) check("stream_order", 32'(got[i]), 32'(i + 1));
      if (got.size() == 8) check("stream_back_to_back", 32'(got_cyc[7] - got_cyc[0]), 32'd7);

      // Backpressure: exactly BUF_DEPTH reads, head held, then the rest in order
      do_reset();
      for (int i = 1; i <= 10; i++) fifo_push(W'(i));
      en = 1'b1; m_ready = 1'b0;
      repeat (12) step();
      check("bp_rd_count", 32'(rd_total), 32'(D));
      check("bp_head_valid", 32'(m_valid), 32'd1);
      check("bp_head_data", 32'(m_data), 32'h0001);
      m_ready = 1'b1;
      repeat (20) step();
      check("bp_words", 32'(got.size()), 32'd10);
      for (int i = 0; i < got.size() && i < 10; i++) check("bp_order", 32'(got[i]), 32'(i + 1));

      // Stop one cycle after a read: pending word still delivered
      do_reset();
      for (int i = 1; i <= 10; i++) fifo_push(W'(i));
      en = 1'b1; m_ready = 1'b1;
      for (int k = 0; k < 10 && rd_total == 0; k++) step();
      check("stop_first_rd_seen", 32'(rd_total != 0), 32'd1);
      en = 1'b0;
      watch_busy = 1;
      repeat (8) step();
      watch_busy = 0;
      check("stop_rd_count", 32'(rd_total), 32'd1);
      check("stop_words", 32'(got.size()), 32'd1);
      if (got.size() >= 1) begin
         check("stop_word", 32'(got[0]), 32'h0001);
         check("stop_busy_fall", 32'(busy_low), 32'(got_cyc[0] + 1));
      end

      // Underflow on the first read: word dropped, sticky error
      do_reset();
      for (int i = 1; i <= 3; i++) fifo_push(W'(i));
      en = 1'b1; m_ready = 1'b1; uf_once = 1;
      repeat (12) step();
      check("uf_err", 32'(underflow_err), 32'd1);
      check("uf_words", 32'(got.size()), 32'd2);
      if (got.size() == 2) begin
         check("uf_word0", 32'(got[0]), 32'h0002);
         check("uf_word1", 32'(got[1]), 32'h0003);
      end
      en = 1'b0;
      repeat (4) step();
      check("uf_err_sticky", 32'(underflow_err), 32'd1);

`ifdef FIFO_READER_STATS_EN
      // Five captured words, three stall cycles
      do_reset();
      for (int i = 1; i <= 5; i++) fifo_push(W'(i));
      en = 1'b1; m_ready = 1'b0;
      for (int k = 0; k < 20 && stall_count < 16'd3; k++) step();
      m_ready = 1'b1;
      repeat (15) step();
      check("stats_rd_count", 32'(rd_count), 32'd5);
      check("stats_stall_count", 32'(stall_count), 32'd3);
`endif

      // Randomized traffic with noise on the FIFO return path
      do_reset();
      noise = 1;
      for (int k = 0; k < 3000; k++) begin
         en      = ($urandom_range(0, 15) != 0);
         m_ready = ($urandom_range(0, 2) != 0);
         if (fifo_q.size() < 6 && $urandom_range(0, 1) == 0) fifo_push(W'($urandom));
         rst_n = ($urandom_range(0, 599) != 0);
         step();
      end
      rst_n = 1'b1;
      noise = 0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fifo_reader.md
Name: fifo_reader

Overview:
- Read-side master for the FIFO block: drives the FIFO's rd_en from its empty flag, captures data_out one cycle after each accepted read, and presents the words on a downstream valid/ready stream.
- Credit-based issue into a small output buffer, so the FIFO is never read unless there is room for the returning word.
- Sits between the FIFO's read port and any consumer (checker, packetiser, output stage).

Parameters:
- FIFO_WIDTH, 16, data width; matches the FIFO data_out width.
- BUF_DEPTH, 4, output buffer entries; minimum 3 for sustained 1 word/cycle, legal range 2..16.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  run enable; 0 stops new reads.
- fifo_empty  in  1  FIFO empty flag.
- fifo_underflow  in  1  FIFO underflow flag; registered, valid the cycle after the read.
- fifo_data_out  in  FIFO_WIDTH  FIFO read data; valid the cycle after an accepted rd_en.
- fifo_rd_en  out  1  read request to the FIFO.
- m_data  out  FIFO_WIDTH  downstream data (buffer head).
- m_valid  out  1  buffer non-empty.
- m_ready  in  1  downstream accept.
- busy  out  1  state != IDLE, or any word pending or buffered.
- underflow_err  out  1  sticky; set if an issued read returns underflow.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - fifo_rd_en=0, m_valid=0, m_data=0, busy=0, underflow_err=0.
  - occ=0, pend=0, state=IDLE.
  - In-flight words are dropped; reset mid-burst needs no recovery.
- Internal state:
  - occ: buffer occupancy, 0..BUF_DEPTH.
  - pend: registered copy of last cycle's fifo_rd_en.
- fifo_rd_en is combinational: (state==RUN) && !fifo_empty && (occ + pend < BUF_DEPTH).
- Capture:
  - If pend==1 and fifo_underflow==0, write fifo_data_out into the buffer at the end of that cycle.
  - Latency: rd_en in cycle N gives m_valid in cycle N+2.
- Pop: when m_valid && m_ready, the head advances.
- Push and pop in the same cycle: occ unchanged; data order preserved (circular buffer, wr/rd pointers wrap modulo BUF_DEPTH).
- m_data and m_valid:
  - Stable while m_valid && !m_ready.
  - m_data is don't-care-free: holds its last value when m_valid=0.
- State machine:
  - IDLE -> RUN when en=1.
  - RUN -> HOLD when occ+pend >= BUF_DEPTH.
  - HOLD -> RUN when space frees and en=1.
  - RUN/HOLD -> IDLE when en=0.
- en=0 mid-stream:
  - No rd_en from that cycle on.
  - A pending word is still captured; buffered words still drain.
  - busy stays 1 until occ==0 and pend==0.
- fifo_empty=1: no rd_en; state stays RUN with no error.
- Underflow on a pending read: word discarded, occ unchanged, underflow_err=1 until reset.
- Buffer full: occ never exceeds BUF_DEPTH; the credit check guarantees no overwrite.

Optional Feature:
- Macro FIFO_READER_STATS_EN.
- Defined: adds outputs rd_count[15:0] and stall_count[15:0], both reset to 0.
  - rd_count increments on each captured word.
  - stall_count increments each cycle m_valid && !m_ready.
  - Both saturate at 16'hFFFF.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package fifo_reader_pkg:
  - Default FIFO_WIDTH constant.
  - State enum typedef (IDLE, RUN, HOLD).
  - Stats counter width constant.
- Sub-module reader_skid_buf: circular buffer with push/pop, occ counter, head data/valid; parameterised by width and depth.
- FSM and credit logic remain in fifo_reader.

Test Plan:
- Reset mid-burst: rst_n=0 for 1 cycle while occ=2, pend=1 -> next cycle m_valid=0, fifo_rd_en=0, busy=0, underflow_err=0.
- Streaming: FIFO preloaded 0x0001..0x0008, en=1, m_ready=1 -> first rd_en cycle N, m_valid at N+2; 8 words in order on 8 consecutive cycles; 8 rd_en pulses total.
- Backpressure: m_ready=0, FIFO holds 10 words -> exactly BUF_DEPTH=4 reads issued; m_data=0x0001 held stable; after m_ready=1 the remaining 6 words follow in order with no loss or duplication.
- Stop: en=0 one cycle after a rd_en -> no further rd_en; the pending word is delivered; busy falls the cycle after the last pop.
- Underflow: force fifo_underflow=1 in the cycle after a rd_en -> word not buffered, occ unchanged, underflow_err=1 and stays set.
- With FIFO_READER_STATS_EN: 5 words captured and 3 stall cycles -> rd_count=5, stall_count=3.
